// File: rtl/lcd_pixel_unpacker.sv
// Re-forms 24-bit {R,G,B} pixels from 32-bit packed FIFO words (three words -> four pixels)
// and presents them as a valid/ready stream with frame position flags and starvation reporting.
module lcd_pixel_unpacker #(
  parameter int unsigned PIXELS_PER_FRAME = 384000,
  parameter int unsigned COUNT_WIDTH      = 19
) (
  input  logic        i_clock,
  input  logic        i_resetN,
  input  logic [31:0] i_fifoData,
  input  logic        i_fifoEmpty,
  output logic        o_fifoRead,
  input  logic        i_frameRestart,
  output logic [23:0] o_pixelData,
  output logic        o_pixelValid,
  input  logic        i_pixelReady,
  output logic        o_firstPixel,
  output logic        o_lastPixel,
  output logic        o_underflow
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PIX_W  = 24;
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(PIXELS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  logic                   en_q;
  logic [1:0]             occ_q, occ_d;
  logic [WORD_W-1:0]      buf0_q, buf0_d, buf1_q, buf1_d;
  logic                   inflight_q, inflight_d;
  phase_e                 phase_q, phase_d;
  logic [PIX_W-1:0]       res_q, res_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]       pix_q, pix_d;
  logic                   valid_q, valid_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   uf_q, uf_d;

  logic                   advance, load, pop, push, rd;
  logic [2:0]             level;
  logic [PIX_W-1:0]       pix_new, res_new;

  // Flow control: the output register frees up, a pixel is formed, the buffer is topped up
  always_comb begin
    advance = !valid_q || i_pixelReady;
    load    = advance && ((phase_q == PH3) || (occ_q != 2'd0));
    pop     = load && (phase_q != PH3);
    push    = inflight_q;
    level   = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd      = en_q && !i_fifoEmpty && !i_frameRestart && (level < 3'd2);
  end

  // Byte alignment of the head word against the carried residue
  always_comb begin
    pix_new = res_q;
    res_new = res_q;
    case (phase_q)
      PH0: begin
        pix_new = buf0_q[31:8];
        res_new = {16'd0, buf0_q[7:0]};
      end
      PH1: begin
        pix_new = {res_q[7:0], buf0_q[31:16]};
        res_new = {8'd0, buf0_q[15:0]};
      end
      PH2: begin
        pix_new = {res_q[15:0], buf0_q[31:24]};
        res_new = buf0_q[23:0];
      end
      default: begin
        pix_new = res_q;
        res_new = res_q;
      end
    endcase
  end

  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rd;
    phase_d    = phase_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    valid_d    = valid_q;
    first_d    = first_q;
    last_d     = last_q;
    uf_d       = i_pixelReady && !valid_q && (cnt_q != '0);

    // Read-ahead never lets occupancy exceed two, so a lone push always finds a free slot
    if (pop && push) begin
      if (occ_q == 2'd2) begin
        buf0_d = buf1_q;
        buf1_d = i_fifoData;
      end else begin
        buf0_d = i_fifoData;
      end
    end else if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end else if (push) begin
      if (occ_q == 2'd0) begin
        buf0_d = i_fifoData;
      end else begin
        buf1_d = i_fifoData;
      end
      occ_d = occ_q + 2'd1;
    end

    if (load) begin
      pix_d   = pix_new;
      valid_d = 1'b1;
      first_d = (cnt_q == '0);
      last_d  = (cnt_q == LAST_IDX);
      cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + COUNT_WIDTH'(1);
      phase_d = phase_e'(phase_q + 2'd1);
      res_d   = res_new;
    end else if (advance) begin
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end

    if (i_frameRestart) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      phase_d    = PH0;
      res_d      = '0;
      cnt_d      = '0;
      pix_d      = '0;
      valid_d    = 1'b0;
      first_d    = 1'b0;
      last_d     = 1'b0;
      uf_d       = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      en_q       <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      inflight_q <= 1'b0;
      phase_q    <= PH0;
      res_q      <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      en_q       <= 1'b1;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      inflight_q <= inflight_d;
      phase_q    <= phase_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      uf_q       <= uf_d;
    end
  end

  // Read request must react to empty/restart in the same cycle; en_q keeps it low in reset
  assign o_fifoRead   = rd;
  assign o_pixelData  = pix_q;
  assign o_pixelValid = valid_q;
  assign o_firstPixel = first_q;
  assign o_lastPixel  = last_q;
  assign o_underflow  = uf_q;

endmodule
